// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM (128 glyphs x 16 rows x 8 bits,
// 1-clk read latency) between four text-overlay ports. Arbitrates once per pixel
// tick, drives the ROM address and realigns the returned glyph row with the granted
// port's column, producing a registered text pixel three clocks after the tick.
// Optional feature: define FONT_ARB_LOCK_EN to keep a glyph cell with the port that
// started drawing it until its last column (bit 7) has been granted.

// Per-port address former: glyph code and row concatenated into a ROM address.
module font_arb_lane (
    input  logic [6:0]  char_code,
    input  logic [3:0]  row,
    output logic [10:0] addr
);
    assign addr = {char_code, row};
endmodule

module font_rom_arbiter #(
    parameter logic [2:0] FG0 = 3'b011,
    parameter logic [2:0] FG1 = 3'b111,
    parameter logic [2:0] FG2 = 3'b100,
    parameter logic [2:0] FG3 = 3'b001,
    parameter logic [2:0] BG  = 3'b110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic [3:0]  req,
    input  logic [27:0] char_addr,
    input  logic [15:0] row_addr,
    input  logic [11:0] bit_addr,
    output logic [10:0] rom_addr,
    input  logic [7:0]  font_word,
    output logic [1:0]  gnt_id,
    output logic        font_bit,
    output logic        text_on,
    output logic [2:0]  text_rgb
);
    localparam int NUM_PORTS = 4;
    localparam int STAGES    = 2;

    // One pipeline stage worth of per-pixel state.
    typedef struct packed {
        logic       v;
        logic [1:0] id;
        logic [2:0] col;
    } stage_t;

    logic [NUM_PORTS-1:0][6:0]  chars;
    logic [NUM_PORTS-1:0][3:0]  rows;
    logic [NUM_PORTS-1:0][2:0]  cols;
    logic [NUM_PORTS-1:0][10:0] lane_addr;
    logic [NUM_PORTS-1:0][2:0]  fg;

    assign chars = char_addr;
    assign rows  = row_addr;
    assign cols  = bit_addr;
    assign fg    = {FG3, FG2, FG1, FG0};

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane
        font_arb_lane u_lane (
            .char_code (chars[k]),
            .row       (rows[k]),
            .addr      (lane_addr[k])
        );
    end

    logic [1:0] prio_id;
    logic       prio_any;
    logic       gnt_vld;
    logic [1:0] gnt_sel;

    // Fixed priority: lowest-numbered requesting port wins.
    always_comb begin
        prio_id  = '0;
        prio_any = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[k]) begin
                prio_id  = 2'(k);
                prio_any = 1'b1;
            end
        end
    end

`ifdef FONT_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state, state_n;
    logic [1:0] lock_id, lock_id_n;

    // Lock state advances only on pixel ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lock_id <= '0;
        end else if (p_tick) begin
            state   <= state_n;
            lock_id <= lock_id_n;
        end
    end

    // Owner keeps the cell while it still requests; otherwise re-arbitrate this tick.
    always_comb begin
        state_n   = state;
        lock_id_n = lock_id;
        gnt_vld   = 1'b0;
        gnt_sel   = prio_id;
        if (state == LOCKED && req[lock_id]) begin
            gnt_vld = 1'b1;
            gnt_sel = lock_id;
            if (cols[lock_id] == 3'd7)
                state_n = IDLE;
        end else if (prio_any) begin
            gnt_vld   = 1'b1;
            gnt_sel   = prio_id;
            lock_id_n = prio_id;
            state_n   = (cols[prio_id] == 3'd7) ? IDLE : LOCKED;
        end else begin
            state_n = IDLE;
        end
    end
`else
    assign gnt_vld = prio_any;
    assign gnt_sel = prio_id;
`endif

    stage_t            s1, s2;
    logic [STAGES:1]   vld_pipe;
    logic              glyph_bit;

    // Tick marker travels alongside the data so stage 3 updates once per tick only.
    always_ff @(posedge clk) begin
        if (reset)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], p_tick};
    end

    // Stage 1: latch winner's address and column; bubbles leave the ROM address alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            s1       <= '0;
        end else if (p_tick) begin
            s1.v <= gnt_vld;
            if (gnt_vld) begin
                rom_addr <= lane_addr[gnt_sel];
                s1.id    <= gnt_sel;
                s1.col   <= cols[gnt_sel];
            end
        end else begin
            s1.v <= 1'b0;
        end
    end

    // Stage 2: wait out the ROM read latency.
    always_ff @(posedge clk) begin
        if (reset)
            s2 <= '0;
        else
            s2 <= s1;
    end

    // Column 0 is the leftmost pixel, i.e. the MSB of the glyph row.
    assign glyph_bit = font_word[~s2.col];

    // Stage 3: produce the pixel on the tick's third edge, hold it otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            font_bit <= 1'b0;
            gnt_id   <= '0;
            text_on  <= 1'b0;
            text_rgb <= BG;
        end else if (vld_pipe[STAGES]) begin
            font_bit <= glyph_bit;
            gnt_id   <= s2.id;
            text_on  <= s2.v;
            text_rgb <= (s2.v && glyph_bit) ? fg[s2.id] : BG;
        end
    end
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed scenarios then randomized ticks, each checked
// against a rule-level reference model of arbitration, locking and the ROM.
module tb_font_rom_arbiter;
    localparam logic [2:0] FGT [4] = '{3'b011, 3'b111, 3'b100, 3'b001};
    localparam logic [2:0] BGC     = 3'b110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic [3:0]  req = '0;
    logic [27:0] char_addr = '0;
    logic [15:0] row_addr = '0;
    logic [11:0] bit_addr = '0;
    logic [10:0] rom_addr;
    logic [7:0]  font_word = '0;
    logic [1:0]  gnt_id;
    logic        font_bit;
    logic        text_on;
    logic [2:0]  text_rgb;

    font_rom_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .req       (req),
        .char_addr (char_addr),
        .row_addr  (row_addr),
        .bit_addr  (bit_addr),
        .rom_addr  (rom_addr),
        .font_word (font_word),
        .gnt_id    (gnt_id),
        .font_bit  (font_bit),
        .text_on   (text_on),
        .text_rgb  (text_rgb)
    );

    always #5 clk = ~clk;

    // Font ROM model: synchronous read, one clock of latency.
    logic [7:0] rom_mem [2048];
    always @(posedge clk) font_word <= rom_mem[rom_addr];

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state
`ifdef FONT_ARB_LOCK_EN
    int owner = -1;
`endif
    logic [10:0] last_addr = '0;
    logic [2:0]  last_col = '0;
    logic [1:0]  last_id = '0;
    logic        exp_on = 1'b0;
    logic        exp_bit = 1'b0;
    logic [2:0]  exp_rgb = BGC;

    logic [3:0][6:0] c;
    logic [3:0][3:0] ro;
    logic [3:0][2:0] b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".text_on"}, 32'(text_on), 32'(exp_on));
        chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(last_id));
        chk({tag, ".font_bit"}, 32'(font_bit), 32'(exp_bit));
        chk({tag, ".text_rgb"}, 32'(text_rgb), 32'(exp_rgb));
    endtask

    // One pixel tick: drive, predict, check rom_addr after the sample edge,
    // check the pixel after edge T+2 and that it is still held one clock later.
    task automatic do_tick(input string tag, input logic [3:0] r);
        int w;
        req = r; char_addr = c; row_addr = ro; bit_addr = b; p_tick = 1'b1;
        w = -1;
`ifdef FONT_ARB_LOCK_EN
        if (owner >= 0 && r[owner]) w = owner;
`endif
        if (w < 0)
            for (int k = 3; k >= 0; k--) if (r[k]) w = k;
`ifdef FONT_ARB_LOCK_EN
        owner = (w >= 0 && b[w] != 3'd7) ? w : -1;
`endif
        if (w >= 0) begin
            last_addr = {c[w], ro[w]};
            last_col  = b[w];
            last_id   = 2'(w);
        end
        @(posedge clk); #1;
        p_tick = 1'b0;
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(last_addr));
        @(posedge clk); @(posedge clk); #1;
        exp_on  = (w >= 0);
        exp_bit = rom_mem[last_addr][7 - int'(last_col)];
        exp_rgb = (exp_on && exp_bit) ? FGT[last_id] : BGC;
        chk_out(tag);
        @(posedge clk); #1;
        chk_out({tag, ".hold"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'hF0;
        c = '0; ro = '0; b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rom_addr", 32'(rom_addr), 32'd0);
        chk_out("reset");
        reset = 1'b0;

        // Single requester on port 2 sweeping one glyph row
        c[2] = 7'h45; ro[2] = 4'd3;
        for (int i = 0; i < 8; i++) begin
            b[2] = 3'(i);
            do_tick("single_p2", 4'b0100);
        end

        // Ports 1 and 3 at column 0: port 1 wins
        c[1] = 7'h21; ro[1] = 4'd6; c[3] = 7'h7E; ro[3] = 4'd9; b = '0;
        do_tick("prio_1_3", 4'b1010);
        b[1] = 3'd7;
        do_tick("prio_release", 4'b0010);

        // Cell lock: port 3 owns the cell, port 0 joins on column 3
        c[0] = 7'h33; ro[0] = 4'd1; b = '0;
        for (int i = 0; i < 8; i++) begin
            b[3] = 3'(i); b[0] = 3'(i);
            do_tick("lock", (i >= 3) ? 4'b1001 : 4'b1000);
        end
        b = '0;
        do_tick("lock_next", 4'b1001);
        b[0] = 3'd7;
        do_tick("lock_p0_end", 4'b0001);

        // Owner drops request while port 1 requests
        b = '0;
        for (int i = 0; i < 5; i++) begin
            b[3] = 3'(i);
            do_tick("owner_hold", 4'b1000);
        end
        b[3] = 3'd5; b[1] = 3'd0;
        do_tick("owner_drop", 4'b0010);
        b[1] = 3'd7;
        do_tick("p1_end", 4'b0010);

        // Hold for 10 clocks with p_tick low, then a bubble tick
        repeat (10) begin
            @(posedge clk); #1;
            chk_out("idle_hold");
        end
        do_tick("bubble", 4'b0000);

        // Reset one clock after a granted tick
        b = '0; b[2] = 3'd2;
        do_tick("pre_reset", 4'b0100);
        b[2] = 3'd3;
        req = 4'b0100; char_addr = c; row_addr = ro; bit_addr = b; p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`ifdef FONT_ARB_LOCK_EN
        owner = -1;
`endif
        last_addr = '0; last_col = '0; last_id = '0;
        exp_on = 1'b0; exp_bit = 1'b0; exp_rgb = BGC;
        chk("mid_reset.rom_addr", 32'(rom_addr), 32'd0);
        chk_out("mid_reset");
        repeat (4) begin
            @(posedge clk); #1;
            chk_out("post_reset");
        end

        // Randomized ticks over randomized ROM contents
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        for (int n = 0; n < 80; n++) begin
            c  = 28'($urandom);
            ro = 16'($urandom);
            b  = 12'($urandom);
            do_tick("rand", 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
